// File: rtl/systolic_drain.sv
// Drains the frozen accumulators of an N x N PE array row-major over valid/ready,
// with optional ReLU, then issues a one-cycle clear and a done pulse.
module systolic_drain #(
    parameter  int N     = 14,
    parameter  int ACC_W = 32,
    localparam int IW    = (N > 1) ? $clog2(N) : 1,
    localparam int EW    = (N > 1) ? $clog2(N*N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               relu_en,
    input  logic [N*N*ACC_W-1:0] acc_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [IW-1:0]      out_row,
    output logic [IW-1:0]      out_col,
    output logic               out_last,
    output logic               clr_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t           state;
    logic [IW-1:0]    row, col;
    logic [EW-1:0]    idx;
    logic             more;
    logic             relu_q;
    logic [ACC_W-1:0] acc_arr [N*N];
    logic [ACC_W-1:0] elem;
    logic             at_end, load, xfer;

    for (genvar e = 0; e < N*N; e++) begin : g_unpack
        assign acc_arr[e] = acc_flat[e*ACC_W +: ACC_W];
    end

    // idx tracks row*N+col so the element select is a plain array index
    assign elem   = acc_arr[idx];
    assign at_end = (row == IW'(N-1)) && (col == IW'(N-1));
    assign load   = (state == DRAIN) && more && (!out_valid || out_ready);
    assign xfer   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
            more      <= 1'b0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            clr_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            clr_out <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        relu_q <= relu_en;
                        row    <= '0;
                        col    <= '0;
                        idx    <= '0;
                        more   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (load) begin
                        out_data  <= (relu_q && elem[ACC_W-1]) ? '0 : elem;
                        out_row   <= row;
                        out_col   <= col;
                        out_last  <= at_end;
                        out_valid <= 1'b1;
                        if (at_end) begin
                            more <= 1'b0;
                        end else begin
                            idx <= idx + EW'(1);
                            if (col == IW'(N-1)) begin
                                col <= '0;
                                row <= row + IW'(1);
                            end else begin
                                col <= col + IW'(1);
                            end
                        end
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    // last element accepted: nothing left to load, so valid falls here too
                    if (xfer && out_last) begin
                        clr_out <= 1'b1;
                        done    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized + directed bench for systolic_drain: an N=2 and an N=14 instance
// checked beat-by-beat against a row-major/ReLU reference list.
module tb_systolic_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, relu_en = 1'b0, out_ready = 1'b0, sel = 1'b0;
    int   pe2 [4];
    int   pe14 [196];
    logic [4*32-1:0]   acc2;
    logic [196*32-1:0] acc14;

    logic        v2, l2, k2, b2, d2, v14, l14, k14, b14, d14;
    logic [31:0] dat2, dat14;
    logic [0:0]  r2, c2;
    logic [3:0]  r14, c14;

    logic        ov, ol, clr, busy, done;
    logic [31:0] od;
    logic [3:0]  orow, ocol;

    int checks = 0, errors = 0;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    always_comb begin
        acc2 = '0;
        for (int i = 0; i < 4; i++) acc2[i*32 +: 32] = pe2[i];
    end
    always_comb begin
        acc14 = '0;
        for (int i = 0; i < 196; i++) acc14[i*32 +: 32] = pe14[i];
    end

    systolic_drain #(.N(2), .ACC_W(32)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .relu_en(relu_en),
        .acc_flat(acc2), .out_valid(v2), .out_ready(out_ready), .out_data(dat2),
        .out_row(r2), .out_col(c2), .out_last(l2), .clr_out(k2), .busy(b2), .done(d2));

    systolic_drain #(.N(14), .ACC_W(32)) u_d14 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .relu_en(relu_en),
        .acc_flat(acc14), .out_valid(v14), .out_ready(out_ready), .out_data(dat14),
        .out_row(r14), .out_col(c14), .out_last(l14), .clr_out(k14), .busy(b14), .done(d14));

    assign ov   = sel ? v14 : v2;
    assign ol   = sel ? l14 : l2;
    assign clr  = sel ? k14 : k2;
    assign busy = sel ? b14 : b2;
    assign done = sel ? d14 : d2;
    assign od   = sel ? dat14 : dat2;
    assign orow = sel ? r14 : {3'b0, r2};
    assign ocol = sel ? c14 : {3'b0, c2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(ov), 0);
        chk({tag, "_data"}, od, 0);
        chk({tag, "_row"}, 32'(orow), 0);
        chk({tag, "_col"}, 32'(ocol), 0);
        chk({tag, "_last"}, 32'(ol), 0);
        chk({tag, "_clr"}, 32'(clr), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // rmode: 0 ready high, 1 random ready, 2 fixed ready pattern; abort_at>0 resets after that many beats
    task automatic drain(input bit use14, input bit relu, input int rmode, input int abort_at,
                         input bit noise);
        int n, beat, first_v, expv;
        bit prev_hold, last_x, fin;
        n = use14 ? 14 : 2;
        sel = use14;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        start = 1'b1;
        relu_en = relu;
        out_ready = 1'b1;
        beat = 0; first_v = -1; prev_hold = 0; last_x = 0; fin = 0;
        for (int it = 1; it <= 1500 && !fin; it++) begin
            @(negedge clk);
            start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            relu_en = ~relu;
            case (rmode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (it >= 2 && it - 2 < 7) ? pat[it-2] : 1'b1;
                default: out_ready = 1'b1;
            endcase
            if (it == 1) chk("busy_rise", 32'(busy), 1);
            if (prev_hold) chk("valid_held", 32'(ov), 1);
            if (ov) begin
                if (first_v < 0) first_v = it;
                if (beat < n*n) begin
                    expv = use14 ? pe14[beat] : pe2[beat];
                    if (relu && expv < 0) expv = 0;
                    chk("data", od, expv);
                    chk("row", 32'(orow), beat / n);
                    chk("col", 32'(ocol), beat % n);
                    chk("last", 32'(ol), 32'(beat == n*n - 1));
                end else begin
                    chk("overrun", 32'(beat), n*n - 1);
                end
            end
            chk("done", 32'(done), 32'(last_x));
            chk("clr", 32'(clr), 32'(last_x));
            if (last_x) begin
                fin = 1;
                chk("beats", beat, n*n);
                if (rmode == 0) begin
                    chk("first_valid", first_v, 2);
                    chk("start_to_done", it, n*n + 2);
                end
            end
            prev_hold = ov && !out_ready;
            last_x    = ov && out_ready && ol;
            if (ov && out_ready) beat++;
            if (abort_at > 0 && beat == abort_at && !fin) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_done", 32'(done), 0);
                    chk("abort_clr", 32'(clr), 0);
                    chk("abort_busy", 32'(busy), 0);
                end
                fin = 1;
            end
        end
        start = 1'b0;
        chk("timeout", 32'(fin), 1);
    endtask

    initial begin
        pe2 = '{5, -3, 7, -100};
        for (int i = 0; i < 196; i++) pe14[i] = i;
        #12;
        sel = 1'b0; #1; chk_zero("rst2");
        sel = 1'b1; #1; chk_zero("rst14");
        @(negedge clk);
        rst_n = 1'b1;

        drain(1'b0, 1'b0, 0, 0, 1'b0);
        drain(1'b0, 1'b1, 0, 0, 1'b0);
        drain(1'b1, 1'b0, 0, 0, 1'b0);
        drain(1'b0, 1'b0, 2, 0, 1'b0);

        for (int i = 0; i < 4; i++) pe2[i] = int'($urandom);
        drain(1'b0, 1'b1, 1, 0, 1'b1);
        drain(1'b0, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 196; i++) pe14[i] = int'($urandom);
        drain(1'b1, 1'b0, 0, 3, 1'b0);
        drain(1'b1, 1'b1, 1, 0, 1'b1);
        drain(1'b1, 1'b0, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Downstream neighbour of the 14×14 weight-stationary PE array. Reads the frozen INT32 accumulators of every PE after a tile completes and streams them out one element per beat, row-major, over a valid/ready interface.
- Optional ReLU is applied on the way out.
- After the final element is accepted, it issues a one-cycle accumulator clear to the array and pulses done.
- The scheduler guarantees PE en=0 for the whole drain; this block does not check it.

Parameters:
- N, 14, array dimension (rows = cols = N).
- ACC_W, 32, accumulator width per PE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a drain; sampled only in IDLE.
- relu_en  in  1  ReLU select; sampled together with an accepted start.
- acc_flat  in  N*N*ACC_W  PE accumulators; PE(r,c) at bits [(r*N+c)*ACC_W +: ACC_W], signed.
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  downstream accepts the element this cycle.
- out_data  out  ACC_W  signed element (post-ReLU when enabled).
- out_row  out  $clog2(N)  row index of out_data.
- out_col  out  $clog2(N)  column index of out_data.
- out_last  out  1  high with element (N-1,N-1).
- clr_out  out  1  one-cycle accumulator clear to all PEs.
- busy  out  1  high in DRAIN and CLEAR.
- done  out  1  one-cycle pulse at drain completion.

Behaviour:
- Reset (async): state=IDLE; out_valid, out_last, clr_out, busy and done = 0; out_data, out_row and out_col = 0; internal row/col counters = 0; relu latch = 0.
- FSM states: IDLE, DRAIN, CLEAR.
- IDLE:
  - On start=1: latch relu_en, set counters to (0,0), go to DRAIN. busy rises the next cycle.
  - start is ignored in all other states; it is neither queued nor an error.
- DRAIN, output register:
  - The output register loads whenever (!out_valid || out_ready) and elements remain.
  - Loaded values: out_data = f(acc_flat[counter element]), out_row/out_col = counters, out_last = (counters == (N-1,N-1)), out_valid = 1.
  - The counters then advance column-first: col wraps N-1→0 and increments row.
- DRAIN, timing:
  - The first element is presented 2 cycles after the start cycle: cycle 1 enters DRAIN, cycle 2 has out_valid=1.
  - With out_ready held high, one element transfers per cycle: N*N consecutive beats, no bubbles.
- Handshake rules:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold stable.
  - out_valid never drops without a transfer.
- ReLU:
  - f(x) = (relu_latch && x[ACC_W-1]) ? 0 : x.
  - No saturation or width change; passes through bit-exact otherwise.
- Completion:
  - When the transfer with out_last=1 occurs, out_valid falls the next cycle and state goes to CLEAR.
  - In CLEAR, for exactly one cycle: clr_out=1 and done=1. Then return to IDLE, where busy=0.
  - A start in that same IDLE cycle is accepted normally.
- acc_flat is sampled at register-load time, not snapshotted. Values must stay frozen from start until clr_out.
- Reset asserted mid-drain aborts immediately to the reset values above. No clr_out or done is produced.
- N=1 is legal: a single beat with out_last=1.

Test Plan:
- N=2, PE values {5,-3,7,-100}, relu_en=0, out_ready=1, start pulse → beats (0,0)=5, (0,1)=-3, (1,0)=7, (1,1)=-100 with last=1. clr_out and done high one cycle after the last beat; busy low the cycle after that.
- Same data, relu_en=1 → stream 5, 0, 7, 0. relu_en toggled mid-drain has no effect.
- N=14, ramp data PE(r,c)=r*14+c, out_ready=1 → 196 back-to-back beats with values 0..195. out_last only on beat 196. Total start-to-done = 198 cycles.
- N=2, out_ready pattern 1,0,0,1,1,0,1 → each element is held stable while ready=0, no element is dropped or duplicated, and the order is unchanged.
- start pulsed during DRAIN and during CLEAR → ignored: a single stream, a single done. A start in the first IDLE cycle after done begins a fresh drain.
- rst_n asserted after the 3rd beat of an N=14 drain → all outputs zero asynchronously. No clr_out or done. A following start drains from (0,0).
